// File: rtl/collapse_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | collapse_bank_pkg                                                    |
// | FSM state type and obfuscation LFSR constants for the collapse bank. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package collapse_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCRUB = 2'd1,
    DEAD  = 2'd2
  } state_e;

  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] c_lfsr_poly = 16'hB400;
  localparam logic [15:0] c_lfsr_seed = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? c_lfsr_poly : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/symbolic_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | symbolic_lfsr                                                        |
// | Free-running Galois LFSR supplying obfuscation words and bases.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module symbolic_lfsr
  import collapse_bank_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = c_lfsr_seed
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] o_lfsr
);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= SEED;
    else       r_lfsr <= lfsr_next(r_lfsr);
  end

  assign o_lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/collapse_bank_symbolic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | collapse_bank_symbolic                                               |
// | Bank of read-once secret cells with basis check and tamper scrub.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module collapse_bank_symbolic
  import collapse_bank_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int BASIS_W   = 2,
  parameter int LFSR_W    = 16,
  parameter int EXT_BASIS = 0,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_init_valid,
  output logic               o_init_ready,
  input  logic [AW-1:0]      i_init_addr,
  input  logic [WIDTH-1:0]   i_init_value,
  input  logic [BASIS_W-1:0] i_init_basis,
  input  logic               i_rd_valid,
  output logic               o_rd_ready,
  input  logic [AW-1:0]      i_rd_addr,
  input  logic [BASIS_W-1:0] i_rd_basis,
  output logic               o_rsp_valid,
  output logic [WIDTH-1:0]   o_rsp_data,
  output logic               o_rsp_match,
  output logic               o_pad_enable,
  output logic               o_fuse_fire,
  input  logic               i_fuse_blow,
  input  logic               i_battery_drop,
  output logic               o_scrub_busy,
  output logic [CW-1:0]      o_live_count
);

  state_e             r_state;
  logic               r_fuse_blown;
  logic [AW-1:0]      r_scrub_cnt;
  logic [WIDTH-1:0]   r_stored    [DEPTH];
  logic [BASIS_W-1:0] r_basis     [DEPTH];
  logic [DEPTH-1:0]   r_collapsed;
  logic [CW-1:0]      r_live_count;
  logic               r_rsp_valid, r_rsp_match, r_fuse_fire;
  logic [WIDTH-1:0]   r_rsp_data;

  logic [LFSR_W-1:0]  w_lfsr;
  logic [WIDTH-1:0]   w_obf;
  logic [BASIS_W-1:0] w_sampled_basis;
  logic               w_tamper, w_init_ready, w_rd_ready, w_init_fire, w_rd_fire;
  logic               w_rd_live, w_hit, w_scrub_live, w_init_new;
  logic [CW:0]        w_up, w_dec, w_net;
  logic [CW-1:0]      w_live_next;

  symbolic_lfsr #(.LFSR_W(LFSR_W), .SEED(LFSR_W'(c_lfsr_seed))) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .o_lfsr (w_lfsr)
  );

  assign w_obf           = w_lfsr[WIDTH-1:0];
  assign w_sampled_basis = w_lfsr[LFSR_W-1 -: BASIS_W];
  assign w_tamper        = i_battery_drop | i_fuse_blow;

  // Tamper onset also drops init_ready so the handshake never claims an init it discards
  assign w_init_ready = (r_state == IDLE) & ~r_fuse_blown & ~w_tamper
                      & ~(i_rd_valid & (i_rd_addr == i_init_addr));
  assign w_rd_ready   = (r_state != SCRUB);
  assign w_init_fire  = i_init_valid & w_init_ready;
  assign w_rd_fire    = i_rd_valid & w_rd_ready;
  assign w_rd_live    = w_rd_fire & ~r_collapsed[i_rd_addr];
  assign w_hit        = w_rd_live & (i_rd_basis == r_basis[i_rd_addr]) & ~r_fuse_blown
                      & (r_state == IDLE) & ~w_tamper;
  assign w_scrub_live = (r_state == SCRUB) & ~r_collapsed[r_scrub_cnt];
  assign w_init_new   = w_init_fire & r_collapsed[i_init_addr];

  always_comb begin
    w_up  = {1'b0, r_live_count} + {{CW{1'b0}}, w_init_new};
    w_dec = {{CW{1'b0}}, w_rd_live} + {{CW{1'b0}}, w_scrub_live};
    w_net = w_up - w_dec;
    if (w_up < w_dec)                  w_live_next = '0;
    else if (w_net > (CW+1)'(DEPTH))   w_live_next = CW'(DEPTH);
    else                               w_live_next = w_net[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_fuse_blown <= 1'b0;
      r_scrub_cnt  <= '0;
      r_collapsed  <= '1;
      r_live_count <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_match  <= 1'b0;
      r_rsp_data   <= '0;
      r_fuse_fire  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_stored[i] <= '0;
        r_basis[i]  <= '0;
      end
    end else begin
      r_rsp_valid  <= w_rd_fire;
      r_rsp_match  <= w_hit;
      r_rsp_data   <= w_hit ? r_stored[i_rd_addr] : w_obf;
      r_fuse_fire  <= w_rd_live;
      r_live_count <= w_live_next;
      if (i_fuse_blow) r_fuse_blown <= 1'b1;

      if (w_init_fire) begin
        r_stored[i_init_addr]    <= i_init_value;
        r_basis[i_init_addr]     <= (EXT_BASIS != 0) ? i_init_basis : w_sampled_basis;
        r_collapsed[i_init_addr] <= 1'b0;
      end
      if (w_rd_live) begin
        r_stored[i_rd_addr]    <= w_obf;
        r_collapsed[i_rd_addr] <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_tamper) begin
            r_state     <= SCRUB;
            r_scrub_cnt <= '0;
          end
        end
        SCRUB: begin
          r_stored[r_scrub_cnt]    <= w_obf;
          r_collapsed[r_scrub_cnt] <= 1'b1;
          if (i_battery_drop) begin
            r_scrub_cnt <= '0;
          end else if (r_scrub_cnt == AW'(DEPTH - 1)) begin
            r_scrub_cnt <= '0;
            r_state     <= (r_fuse_blown | i_fuse_blow) ? DEAD : IDLE;
          end else begin
            r_scrub_cnt <= r_scrub_cnt + 1'b1;
          end
        end
        DEAD:    r_state <= DEAD;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_init_ready = w_init_ready;
  assign o_rd_ready   = w_rd_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_match  = r_rsp_match;
  assign o_fuse_fire  = r_fuse_fire;
  assign o_scrub_busy = (r_state == SCRUB);
  assign o_live_count = r_live_count;
  assign o_pad_enable = r_rsp_valid & r_rsp_match & ~r_fuse_blown & (r_state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_collapse_bank_symbolic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_collapse_bank_symbolic                                            |
// | Table, directed and random checks of the collapse bank.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_collapse_bank_symbolic;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iv = 1'b0, rv = 1'b0, bd = 1'b0, fb = 1'b0;
  logic [3:0] ia = '0, ra = '0;
  logic [7:0] ival = '0;
  logic [1:0] ib = '0, rb = '0;

  logic       o_init_ready, o_rd_ready, o_rsp_valid, o_rsp_match;
  logic       o_pad_enable, o_fuse_fire, o_scrub_busy;
  logic [7:0] o_rsp_data;
  logic [4:0] o_live_count;

  collapse_bank_symbolic #(
    .WIDTH(8), .DEPTH(16), .BASIS_W(2), .LFSR_W(16), .EXT_BASIS(1)
  ) dut (
    .clk(clk), .reset(reset),
    .i_init_valid(iv), .o_init_ready(o_init_ready), .i_init_addr(ia),
    .i_init_value(ival), .i_init_basis(ib),
    .i_rd_valid(rv), .o_rd_ready(o_rd_ready), .i_rd_addr(ra), .i_rd_basis(rb),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_match(o_rsp_match),
    .o_pad_enable(o_pad_enable), .o_fuse_fire(o_fuse_fire),
    .i_fuse_blow(fb), .i_battery_drop(bd),
    .o_scrub_busy(o_scrub_busy), .o_live_count(o_live_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 scrubbing, 2 dead
  logic [15:0] m_lfsr;
  logic [7:0]  m_val [16];
  logic [1:0]  m_bas [16];
  bit          m_live[16];
  int          m_mode, m_pos;
  bit          m_blown;
  bit          e_valid, e_match, e_fire;
  logic [7:0]  e_data;
  logic        s_ir;

  typedef struct {
    bit iv; int ia; int ival; int ib;
    bit rv; int ra; int rb; bit bd;
    bit e_ir; bit e_valid; bit e_match; int e_data; bit e_fire; bit e_pad; int e_live;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int live_sum();
    int s = 0;
    for (int i = 0; i < 16; i++) s += m_live[i] ? 1 : 0;
    return s;
  endfunction

  function automatic bit m_init_ready();
    return m_mode == 0 && !m_blown && !(bd || fb) && !(rv && ra == ia);
  endfunction

  function automatic void model_reset();
    m_lfsr = 16'hACE1; m_mode = 0; m_pos = 0; m_blown = 0;
    for (int i = 0; i < 16; i++) begin m_val[i] = '0; m_bas[i] = '0; m_live[i] = 0; end
  endfunction

  function automatic void model_step();
    bit         tamper = bd || fb;
    bit         ir = m_init_ready();
    logic [7:0] obf = m_lfsr[7:0];
    e_valid = rv && (m_mode != 1);
    e_match = e_valid && m_live[ra] && rb == m_bas[ra] && !m_blown && m_mode == 0 && !tamper;
    e_data  = e_match ? m_val[ra] : obf;
    e_fire  = e_valid && m_live[ra];
    if (e_fire) m_live[ra] = 0;
    if (iv && ir) begin m_val[ia] = ival; m_bas[ia] = ib; m_live[ia] = 1; end
    if (fb) m_blown = 1;
    if (m_mode == 1) begin
      m_live[m_pos] = 0;
      if (bd) m_pos = 0;
      else if (m_pos == 15) m_mode = m_blown ? 2 : 0;
      else m_pos++;
    end else if (m_mode == 0 && tamper) begin
      m_mode = 1; m_pos = 0;
    end
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic step();
    @(negedge clk);
    s_ir = o_init_ready;
    chk("init_ready", o_init_ready, m_init_ready());
    chk("rd_ready", o_rd_ready, m_mode != 1);
    @(posedge clk);
    model_step();
    #1;
    chk("rsp_valid", o_rsp_valid, e_valid);
    if (e_valid) begin
      chk("rsp_match", o_rsp_match, e_match);
      chk("rsp_data", o_rsp_data, e_data);
    end
    chk("fuse_fire", o_fuse_fire, e_fire);
    chk("pad_enable", o_pad_enable, e_valid && e_match && !m_blown && m_mode == 0);
    chk("scrub_busy", o_scrub_busy, m_mode == 1);
    chk("live_count", o_live_count, live_sum());
  endtask

  task automatic idle_inputs();
    iv = 0; rv = 0; bd = 0; fb = 0; ia = '0; ra = '0; ival = '0; ib = '0; rb = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    model_reset();
    #1 reset = 0;
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_fuse_fire", o_fuse_fire, 0);
    chk("rst_pad", o_pad_enable, 0);
    chk("rst_busy", o_scrub_busy, 0);
    chk("rst_live", o_live_count, 0);
    chk("rst_init_ready", o_init_ready, 1);
    chk("rst_rd_ready", o_rd_ready, 1);
  endtask

  initial begin
    int busy_cnt;
    bit any_match;
    tbl[0]  = '{1, 3, 'h5A, 2, 0, 0, 0, 0, 1, 0, 0, 0,     0, 0, 1};
    tbl[1]  = '{0, 0, 0,    0, 1, 3, 2, 0, 1, 1, 1, 'h5A, 1, 1, 0};
    tbl[2]  = '{0, 0, 0,    0, 1, 3, 2, 0, 1, 1, 0, 0,     0, 0, 0};
    tbl[3]  = '{1, 5, 'h33, 1, 0, 0, 0, 0, 1, 0, 0, 0,     0, 0, 1};
    tbl[4]  = '{0, 0, 0,    0, 1, 5, 3, 0, 1, 1, 0, 0,     1, 0, 0};
    tbl[5]  = '{0, 0, 0,    0, 1, 5, 1, 0, 1, 1, 0, 0,     0, 0, 0};
    tbl[6]  = '{1, 7, 'h11, 0, 0, 0, 0, 0, 1, 0, 0, 0,     0, 0, 1};
    tbl[7]  = '{1, 7, 'hFF, 3, 1, 7, 0, 0, 0, 1, 1, 'h11, 1, 1, 0};
    tbl[8]  = '{1, 9, 'h44, 1, 1, 7, 0, 0, 1, 1, 0, 0,     0, 0, 1};
    tbl[9]  = '{0, 0, 0,    0, 1, 9, 1, 0, 1, 1, 1, 'h44, 1, 1, 0};
    tbl[10] = '{1, 2, 'h77, 1, 0, 0, 0, 0, 1, 0, 0, 0,     0, 0, 1};
    tbl[11] = '{1, 4, 'h01, 0, 1, 2, 1, 1, 0, 1, 0, 0,     1, 0, 0};

    do_reset();

    // Directed table of handshake and collapse cases
    for (int i = 0; i < 12; i++) begin
      iv = tbl[i].iv; ia = 4'(tbl[i].ia); ival = 8'(tbl[i].ival); ib = 2'(tbl[i].ib);
      rv = tbl[i].rv; ra = 4'(tbl[i].ra); rb = 2'(tbl[i].rb); bd = tbl[i].bd; fb = 0;
      step();
      chk($sformatf("tbl%0d_init_ready", i), s_ir, tbl[i].e_ir);
      chk($sformatf("tbl%0d_rsp_valid", i), o_rsp_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_rsp_match", i), o_rsp_match, tbl[i].e_match);
      if (tbl[i].e_match) chk($sformatf("tbl%0d_rsp_data", i), o_rsp_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_fuse_fire", i), o_fuse_fire, tbl[i].e_fire);
      chk($sformatf("tbl%0d_pad", i), o_pad_enable, tbl[i].e_pad);
      chk($sformatf("tbl%0d_live", i), o_live_count, tbl[i].e_live);
    end
    idle_inputs();
    repeat (20) step();

    // Fill every cell, then a battery_drop that restarts mid-scrub
    for (int i = 0; i < 16; i++) begin
      iv = 1; ia = 4'(i); ival = 8'($urandom); ib = 2'($urandom_range(0, 3));
      step();
    end
    idle_inputs();
    step();
    chk("fill_live16", o_live_count, 16);
    busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      bd = (c == 0 || c == 7);
      step();
      if (o_scrub_busy) busy_cnt++;
    end
    bd = 0;
    chk("restart_busy_cycles", busy_cnt, 23);
    chk("restart_live0", o_live_count, 0);
    iv = 1; ia = 4'd6; ival = 8'h5C; ib = 2'd3;
    step();
    iv = 0; rv = 1; ra = 4'd6; rb = 2'd3;
    step();
    chk("reinit_match", o_rsp_match, 1);
    chk("reinit_data", o_rsp_data, 8'h5C);
    idle_inputs();

    // Randomized traffic with occasional power loss
    for (int c = 0; c < 800; c++) begin
      iv = 1'($urandom); ia = 4'($urandom); ival = 8'($urandom); ib = 2'($urandom);
      rv = 1'($urandom); ra = 4'($urandom); rb = 2'($urandom);
      bd = ($urandom_range(0, 63) == 0);
      step();
    end
    idle_inputs();
    repeat (20) step();

    // Reset in the middle of a scrub
    for (int i = 0; i < 4; i++) begin iv = 1; ia = 4'(i); ival = 8'(i + 1); step(); end
    idle_inputs(); bd = 1; step(); bd = 0;
    repeat (5) step();
    do_reset();

    // Permanent fuse: scrub then dead until reset
    iv = 1; ia = 4'd1; ival = 8'hA5; ib = 2'd2; step();
    idle_inputs(); fb = 1; step(); fb = 0;
    busy_cnt = 1;
    any_match = 0;
    for (int c = 0; c < 60; c++) begin
      iv = 1; ia = 4'($urandom); ival = 8'($urandom); ib = 2'($urandom);
      rv = 1; ra = 4'($urandom); rb = 2'($urandom);
      step();
      if (o_scrub_busy) busy_cnt++;
      if (o_rsp_match || o_pad_enable) any_match = 1;
    end
    chk("fuse_busy_cycles", busy_cnt, 16);
    chk("dead_init_ready", s_ir, 0);
    chk("dead_no_match", any_match, 0);
    chk("dead_live0", o_live_count, 0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
